conv_mem_responder: RTL
=======================

// Module: conv_mem_responder
// PURPOSE
//  Memory-side responder for the image-convolution engine interface. Holds the
//  64x64 input image plus the layer-0 (conv/ReLU) and layer-1 (max-pool)
//  result memories. Loads the image serially, raises ready to start the
//  engine, and serves its iaddr/idata, cwr/caddr_wr/cdata_wr and
//  crd/caddr_rd/cdata_rd traffic. When the engine's busy falls, it streams the
//  layer-1 results out for checking.
// PARAMETERS
//  DW        20    data width, signed 4.16 fixed point
//  AW        12    address width of iaddr, caddr_wr and caddr_rd
//  IMG_DEPTH 4096  image words; also the layer-0 depth
//  L1_DEPTH  1024  layer-1 words
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, asynchronous, active-high
//  load_valid in   1   image load strobe; one word per cycle while high
//  load_data  in   DW  image word, written at the load address counter
//  ready      out  1   engine start request
//  busy       in   1   engine busy
//  iaddr      in   AW  image read address
//  idata      out  DW  image read data
//  cwr        in   1   layer write enable
//  caddr_wr   in   AW  layer write address
//  cdata_wr   in   DW  layer write data
//  crd        in   1   layer read enable
//  caddr_rd   in   AW  layer read address
//  cdata_rd   out  DW  layer read data
//  csel       in   3   bank select: 3'b001 = L0, 3'b011 = L1
//  done       out  1   one-cycle pulse when the engine completes
//  dump_valid out  1   L1 dump word valid
//  dump_last  out  1   last dump word, coincident with dump_valid
//  dump_data  out  DW  L1 dump word
//  err        out  1   sticky: illegal csel or out-of-range access seen
// BEHAVIOUR
//  FSM states: LOAD, START, RUN, DUMP, IDLE. Reset enters LOAD.
//  Reset values: ready=0, done=0, dump_valid=0, dump_last=0, dump_data=0,
//   err=0; load counter and dump counter = 0.
//  Memory arrays are not reset; contents survive a reset.
//  LOAD:
//   - Each cycle with load_valid=1 writes img[ld_cnt] and increments ld_cnt.
//   - The write of word IMG_DEPTH-1 moves to START.
//   - load_valid outside LOAD is ignored.
//  START:
//   - ready=1, registered.
//   - Move to RUN on the first cycle busy is sampled 1; ready drops that same
//     edge.
//   - busy already 1 on entry: go straight to RUN after one cycle of ready.
//  RUN:
//   - idata = img[iaddr], combinational (asynchronous read), no latency. The
//     engine registers iaddr and consumes idata in the next cycle.
//   - cdata_rd = bank(csel)[caddr_rd] when crd=1, combinational; 0 when
//     crd=0. An illegal csel returns 0.
//   - cwr=1 writes cdata_wr into bank(csel)[caddr_wr] at the clock edge.
//   - Simultaneous cwr and crd to the same bank and address: cdata_rd shows
//     the old word; the new word is visible the next cycle.
//   - L1 address >= L1_DEPTH on write: write dropped, err set. Same address on
//     read: returns 0, err set.
//   - Illegal csel with cwr or crd asserted sets err. No other effect.
//   - busy 1->0 (registered previous-busy compare): done=1 for one cycle, go
//     to DUMP.
//  DUMP:
//   - Streams L1[0..L1_DEPTH-1], one word per cycle, dump_valid=1 throughout.
//   - dump_data is registered: the word for index k appears the cycle after
//     index k is selected.
//   - dump_last=1 with index L1_DEPTH-1, then go to IDLE. No back-pressure.
//  IDLE:
//   - load_valid=1 returns to LOAD: writes that word at address 0, clears err.
//  Engine accesses outside RUN are still served; idata and cdata_rd are always
//   live. Writes outside RUN are accepted too.
//  Reset mid-operation: FSM to LOAD, counters 0, pulses dropped; no partial
//   dump.
// TESTING
//  1) Load img[i]=i (4096 words) -> ready rises 1 cycle after the last word;
//     busy=1 -> ready=0 next edge.
//  2) RUN, iaddr=12'd130 -> idata=20'd130 in the same cycle. iaddr=4095 ->
//     idata=4095.
//  3) csel=001, cwr, caddr_wr=5, data 20'h1ABCD. Next cycle crd, caddr_rd=5 ->
//     cdata_rd=20'h1ABCD. Same-cycle wr+rd to the same address -> old value.
//  4) csel=011, write caddr_wr=1024 -> err=1 and L1 unchanged. csel=010 with
//     crd -> cdata_rd=0, err=1.
//  5) Write L1[k]=k+7, drop busy -> done pulse; 1024 dump words k+7 in order,
//     dump_last on the 1024th, then IDLE.
//  6) Assert reset during DUMP at word 300 -> dump_valid=0 immediately; LOAD
//     state; a reload restarts from address 0.

Source files
------------

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the image-convolution engine: image store, layer-0/layer-1
// result banks, serial image load, engine start handshake and layer-1 result dump.
module conv_mem_responder #(
    parameter int DW        = 20,
    parameter int AW        = 12,
    parameter int IMG_DEPTH = 4096,
    parameter int L1_DEPTH  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          done,
    output logic          dump_valid,
    output logic          dump_last,
    output logic [DW-1:0] dump_data,
    output logic          err
);

    localparam int L1AW = $clog2(L1_DEPTH);

    typedef enum logic [2:0] {LOAD, START, RUN, DUMP, IDLE} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   ld_cnt;
    logic [L1AW-1:0] dp_cnt;
    logic            busy_q;

    logic [DW-1:0] img_mem [IMG_DEPTH];
    logic [DW-1:0] l0_mem  [IMG_DEPTH];
    logic [DW-1:0] l1_mem  [L1_DEPTH];

    logic          sel_l0, sel_l1, sel_bad;
    logic          l1_wr_in, l1_rd_in;
    logic          load_wr, reload;
    logic [AW-1:0] img_wa;
    logic          err_hit;
    logic          dp_end;

    assign sel_l0   = (csel == 3'b001);
    assign sel_l1   = (csel == 3'b011);
    assign sel_bad  = !sel_l0 && !sel_l1;
    assign l1_wr_in = ({1'b0, caddr_wr} < (AW+1)'(L1_DEPTH));
    assign l1_rd_in = ({1'b0, caddr_rd} < (AW+1)'(L1_DEPTH));

    // A load strobe in IDLE restarts loading: that word lands at address 0.
    assign reload  = (state == IDLE) && load_valid;
    assign load_wr = ((state == LOAD) && load_valid) || reload;
    assign img_wa  = reload ? '0 : ld_cnt;
    assign dp_end  = (dp_cnt == L1AW'(L1_DEPTH-1));

    assign err_hit = (sel_bad && (cwr || crd))
                   || (sel_l1 && cwr && !l1_wr_in)
                   || (sel_l1 && crd && !l1_rd_in);

    assign idata = img_mem[iaddr];

    always_comb begin
        cdata_rd = '0;
        if (crd) begin
            if (sel_l0)
                cdata_rd = l0_mem[caddr_rd];
            else if (sel_l1 && l1_rd_in)
                cdata_rd = l1_mem[caddr_rd[L1AW-1:0]];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:  if (load_valid && ld_cnt == AW'(IMG_DEPTH-1)) state_n = START;
            START: if (busy) state_n = RUN;
            RUN:   if (busy_q && !busy) state_n = DUMP;
            DUMP:  if (dp_end) state_n = IDLE;
            IDLE:  if (load_valid) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            ld_cnt     <= '0;
            dp_cnt     <= '0;
            busy_q     <= 1'b0;
            ready      <= 1'b0;
            done       <= 1'b0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_data  <= '0;
            err        <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= busy;
            ready  <= (state_n == START);
            done   <= (state == RUN) && (state_n == DUMP);

            if (reload)
                ld_cnt <= AW'(1);
            else if ((state == LOAD) && load_valid)
                ld_cnt <= ld_cnt + 1'b1;

            if (state == DUMP) begin
                dump_valid <= 1'b1;
                dump_last  <= dp_end;
                dump_data  <= l1_mem[dp_cnt];
                dp_cnt     <= dp_end ? '0 : dp_cnt + 1'b1;
            end else begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end

            err <= reload ? err_hit : (err | err_hit);
        end
    end

    // Storage has no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (load_wr)
            img_mem[img_wa] <= load_data;
        if (cwr && sel_l0)
            l0_mem[caddr_wr] <= cdata_wr;
        if (cwr && sel_l1 && l1_wr_in)
            l1_mem[caddr_wr[L1AW-1:0]] <= cdata_wr;
    end

endmodule
